// File: rtl/mem_controller_mc.sv
`default_nettype none
// ============================================================================
// Module   : mem_controller_mc
// Function : Round-robin multi-channel memory controller with fixed-latency
//            response pipeline and credit-protected response queue.
// Revision : 1.0
// ============================================================================
module mem_controller_mc #(
   parameter int NUM_CH     = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 31,
   parameter int TID_WIDTH  = 16,
   parameter int MEM_DEPTH  = 256,
   parameter int LATENCY    = 3,
   parameter int RESP_DEPTH = 8,
   localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int REQ_WIDTH      = 1 + ADDR_WIDTH + DATA_WIDTH,
   localparam int DP_DATA_WIDTH  = TID_WIDTH + REQ_WIDTH,
   localparam int VPI_DATA_WIDTH = 1 + CH_W + TID_WIDTH + DATA_WIDTH,
   localparam int CNT_W          = $clog2(RESP_DEPTH) + 1
) (
   input  logic                            clk,
   input  logic                            reset,
   output logic [NUM_CH-1:0]               read_ctr,
   input  logic [NUM_CH*DP_DATA_WIDTH-1:0] incoming_data,
   input  logic [NUM_CH-1:0]               empty_signal,
   output logic                            write_ctr,
   output logic [VPI_DATA_WIDTH-1:0]       outgoing_data,
   input  logic                            full_signal,
   output logic [CNT_W-1:0]                pending_count
);
   localparam int MIDX_W = $clog2(MEM_DEPTH);
   localparam int QP_W   = $clog2(RESP_DEPTH);

   logic [CH_W-1:0]           r_rr;
   logic [CH_W-1:0]           w_gidx;
   logic [CH_W:0]             w_sum;
   logic [2*NUM_CH-1:0]       w_dbl;
   logic [NUM_CH-1:0]         w_rot;
   logic                      w_found;
   logic                      w_go;
   logic [DP_DATA_WIDTH-1:0]  w_req;
   logic [TID_WIDTH-1:0]      w_tid;
   logic                      w_rw;
   logic [ADDR_WIDTH-1:0]     w_addr;
   logic [DATA_WIDTH-1:0]     w_wdata;
   logic [DATA_WIDTH-1:0]     w_rdata;
   logic [DATA_WIDTH-1:0]     w_rsp_data;
   logic                      w_oor;
   logic [MIDX_W-1:0]         w_idx;
   logic [VPI_DATA_WIDTH-1:0] w_resp;

   logic [DATA_WIDTH-1:0]     r_mem [MEM_DEPTH];
   logic [LATENCY-1:0]        r_pv;
   logic [VPI_DATA_WIDTH-1:0] r_pd [LATENCY];
   logic [VPI_DATA_WIDTH-1:0] r_q [RESP_DEPTH];
   logic [QP_W-1:0]           r_wp;
   logic [QP_W-1:0]           r_rp;
   logic [CNT_W-1:0]          r_cnt;
   logic [CNT_W-1:0]          r_pend;
   logic [VPI_DATA_WIDTH-1:0] r_hold;
   logic                      w_push;
   logic                      w_pop;
   logic                      w_qempty;

   // Rotate the request vector so bit 0 is the rr pointer; lowest set bit wins.
   always_comb begin
      w_dbl   = {~empty_signal, ~empty_signal};
      w_rot   = w_dbl[r_rr +: NUM_CH];
      w_found = 1'b0;
      w_sum   = '0;
      for (int j = NUM_CH - 1; j >= 0; j--) begin
         if (w_rot[j]) begin
            w_found = 1'b1;
            w_sum   = {1'b0, r_rr} + (CH_W+1)'(j);
         end
      end
      if (w_sum >= (CH_W+1)'(NUM_CH))
         w_sum = w_sum - (CH_W+1)'(NUM_CH);
      w_gidx = w_sum[CH_W-1:0];
      w_go   = w_found && !reset && (r_pend < CNT_W'(RESP_DEPTH));
   end

   always_comb begin
      read_ctr = '0;
      w_req    = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         read_ctr[c] = w_go && (w_gidx == CH_W'(c));
         if (w_gidx == CH_W'(c))
            w_req = incoming_data[c*DP_DATA_WIDTH +: DP_DATA_WIDTH];
      end
   end

   assign w_tid      = w_req[DP_DATA_WIDTH-1 -: TID_WIDTH];
   assign w_rw       = w_req[REQ_WIDTH-1];
   assign w_addr     = w_req[DATA_WIDTH +: ADDR_WIDTH];
   assign w_wdata    = w_req[DATA_WIDTH-1:0];
   assign w_oor      = |(w_addr >> MIDX_W);
   assign w_idx      = w_addr[MIDX_W-1:0];
   assign w_rdata    = r_mem[w_idx];
   assign w_rsp_data = w_oor ? {DATA_WIDTH{1'b0}} : (w_rw ? w_rdata : w_wdata);
   assign w_resp     = {w_oor, w_gidx, w_tid, w_rsp_data};

   always_ff @(posedge clk) begin
      if (w_go && !w_rw && !w_oor)
         r_mem[w_idx] <= w_wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pv <= '0;
      end else begin
         r_pv[0] <= w_go;
         for (int i = 1; i < LATENCY; i++)
            r_pv[i] <= r_pv[i-1];
      end
   end

   always_ff @(posedge clk) begin
      r_pd[0] <= w_resp;
      for (int i = 1; i < LATENCY; i++)
         r_pd[i] <= r_pd[i-1];
      if (w_push)
         r_q[r_wp] <= r_pd[LATENCY-1];
   end

   assign w_push        = r_pv[LATENCY-1];
   assign w_qempty      = (r_cnt == '0);
   assign write_ctr     = !w_qempty && !full_signal;
   assign w_pop         = write_ctr;
   assign outgoing_data = w_qempty ? r_hold : r_q[r_rp];
   assign pending_count = r_pend;

   // r_pend counts grants not yet popped, i.e. pipeline stages plus queue.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wp   <= '0;
         r_rp   <= '0;
         r_cnt  <= '0;
         r_pend <= '0;
         r_hold <= '0;
         r_rr   <= '0;
      end else begin
         if (w_push)
            r_wp <= r_wp + 1'b1;
         if (w_pop) begin
            r_rp   <= r_rp + 1'b1;
            r_hold <= r_q[r_rp];
         end
         r_cnt  <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
         r_pend <= r_pend + CNT_W'(w_go) - CNT_W'(w_pop);
         if (w_go)
            r_rr <= (w_gidx == CH_W'(NUM_CH - 1)) ? '0 : w_gidx + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_controller_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_controller_mc
// Function : Self-checking bench for mem_controller_mc against a queue-based
//            reference model of the request FIFOs, memory and responses.
// Revision : 1.0
// ============================================================================
module tb_mem_controller_mc;
   localparam int NUM_CH     = 4;
   localparam int DW         = 32;
   localparam int AW         = 31;
   localparam int TW         = 16;
   localparam int MEM_DEPTH  = 256;
   localparam int LATENCY    = 3;
   localparam int RESP_DEPTH = 8;
   localparam int CH_W       = 2;
   localparam int DPW        = TW + 1 + AW + DW;
   localparam int VW         = 1 + CH_W + TW + DW;
   localparam int PCW        = 4;

   logic                    clk;
   logic                    reset;
   logic [NUM_CH-1:0]       read_ctr;
   logic [NUM_CH*DPW-1:0]   incoming_data;
   logic [NUM_CH-1:0]       empty_signal;
   logic                    write_ctr;
   logic [VW-1:0]           outgoing_data;
   logic                    full_signal;
   logic [PCW-1:0]          pending_count;

   mem_controller_mc #(
      .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TID_WIDTH(TW),
      .MEM_DEPTH(MEM_DEPTH), .LATENCY(LATENCY), .RESP_DEPTH(RESP_DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .read_ctr(read_ctr),
      .incoming_data(incoming_data), .empty_signal(empty_signal),
      .write_ctr(write_ctr), .outgoing_data(outgoing_data),
      .full_signal(full_signal), .pending_count(pending_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [DPW-1:0] fq [NUM_CH][$];
   logic [VW-1:0]  inf_q [$];
   int             due_q [$];
   logic [VW-1:0]  rq [$];
   logic [DW-1:0]  mem [MEM_DEPTH];
   logic [VW-1:0]  last_out;
   logic           full_m;
   int             rr;
   int             cyc;
   int             n_assert;
   int             n_fail;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_req(input int ch, input logic [TW-1:0] tid, input logic rw,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data);
      fq[ch].push_back({tid, rw, addr, data});
   endtask

   function automatic int pending_m();
      return inf_q.size() + rq.size();
   endfunction

   function automatic int exp_grant();
      int c;
      if (reset || pending_m() >= RESP_DEPTH) return -1;
      for (int i = 0; i < NUM_CH; i++) begin
         c = (rr + i) % NUM_CH;
         if (fq[c].size() > 0) return c;
      end
      return -1;
   endfunction

   function automatic logic busy();
      logic b;
      b = (pending_m() > 0);
      for (int c = 0; c < NUM_CH; c++)
         if (fq[c].size() > 0) b = 1'b1;
      return b;
   endfunction

   task automatic drive();
      for (int c = 0; c < NUM_CH; c++) begin
         empty_signal[c] = (fq[c].size() == 0);
         incoming_data[c*DPW +: DPW] = (fq[c].size() > 0) ? fq[c][0] : '0;
      end
      full_signal = full_m;
   endtask

   task automatic model_edge(input int g, input logic wr);
      logic [DPW-1:0] req;
      logic [TW-1:0]  tid;
      logic           rw;
      logic [AW-1:0]  addr;
      logic [DW-1:0]  d;
      logic [VW-1:0]  resp;
      if (g >= 0) begin
         req  = fq[g].pop_front();
         tid  = req[DPW-1 -: TW];
         rw   = req[AW+DW];
         addr = req[DW +: AW];
         d    = req[DW-1:0];
         if (addr >= AW'(MEM_DEPTH))
            resp = {1'b1, 2'(g), tid, 32'h0};
         else if (rw)
            resp = {1'b0, 2'(g), tid, mem[addr[7:0]]};
         else begin
            mem[addr[7:0]] = d;
            resp = {1'b0, 2'(g), tid, d};
         end
         inf_q.push_back(resp);
         due_q.push_back(cyc + LATENCY);
         rr = (g + 1) % NUM_CH;
      end
      if (wr) last_out = rq.pop_front();
      while (due_q.size() > 0 && due_q[0] == cyc) begin
         void'(due_q.pop_front());
         rq.push_back(inf_q.pop_front());
      end
      cyc++;
   endtask

   // One clock cycle: drive after negedge, check, advance model at posedge.
   task automatic step();
      int            g;
      logic [3:0]    exp_rc;
      logic          exp_wr;
      logic [VW-1:0] exp_out;
      drive();
      #1;
      g       = exp_grant();
      exp_rc  = (g >= 0) ? 4'(1 << g) : 4'b0;
      exp_wr  = (rq.size() > 0) && !full_m;
      exp_out = (rq.size() > 0) ? rq[0] : last_out;
      chk("read_ctr", 64'(read_ctr), 64'(exp_rc));
      chk("write_ctr", 64'(write_ctr), 64'(exp_wr));
      chk("outgoing_data", 64'(outgoing_data), 64'(exp_out));
      chk("pending_count", 64'(pending_count), 64'(pending_m()));
      @(posedge clk);
      model_edge(g, exp_wr);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst_read_ctr", 64'(read_ctr), 64'h0);
      chk("rst_write_ctr", 64'(write_ctr), 64'h0);
      chk("rst_outgoing", 64'(outgoing_data), 64'h0);
      chk("rst_pending", 64'(pending_count), 64'h0);
      inf_q.delete();
      due_q.delete();
      rq.delete();
      rr = 0;
      last_out = '0;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic drain(input int budget);
      int k;
      k = 0;
      while (busy() && k < budget) begin
         step();
         k++;
      end
      chk("drain_timeout", 64'(busy()), 64'h0);
   endtask

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(7) == 0) return AW'($urandom);
      return AW'($urandom_range(MEM_DEPTH - 1));
   endfunction

   initial begin
      n_assert = 0; n_fail = 0; rr = 0; cyc = 0; last_out = '0; full_m = 1'b0;
      reset = 1'b1; empty_signal = '1; incoming_data = '0; full_signal = 1'b0;
      @(posedge clk);
      @(negedge clk);
      do_reset();

      // Give every memory word a known value
      for (int i = 0; i < MEM_DEPTH; i++)
         push_req(0, TW'(i), 1'b0, AW'(i), $urandom);
      drain(700);

      // Write then read one address on channel 0
      push_req(0, 16'd5, 1'b0, 31'h10, 32'hDEADBEEF);
      push_req(0, 16'd6, 1'b1, 31'h10, 32'h0);
      drain(50);

      // All channels busy: round-robin rotation
      for (int k = 0; k < 6; k++)
         for (int c = 0; c < NUM_CH; c++)
            push_req(c, 16'($urandom), 1'($urandom), AW'($urandom_range(MEM_DEPTH - 1)), $urandom);
      drain(100);

      // Back-pressure: credit limit stops grants at RESP_DEPTH
      full_m = 1'b1;
      for (int k = 0; k < 12; k++)
         push_req(0, 16'(100 + k), 1'b1, AW'(k), 32'h0);
      repeat (20) step();
      full_m = 1'b0;
      drain(100);

      // Out-of-range address, then word 0 still intact
      push_req(1, 16'd7, 1'b1, 31'h100, 32'h0);
      push_req(1, 16'd8, 1'b0, 31'h100, 32'h12345678);
      push_req(1, 16'd9, 1'b1, 31'h0, 32'h0);
      drain(50);

      // Reset with three responses in flight
      push_req(2, 16'd20, 1'b0, 31'h30, 32'hCAFEF00D);
      push_req(2, 16'd21, 1'b1, 31'h10, 32'h0);
      push_req(2, 16'd22, 1'b1, 31'h30, 32'h0);
      repeat (3) step();
      do_reset();
      repeat (8) step();

      // Cross-channel write then read of the same word on consecutive edges
      push_req(0, 16'd30, 1'b0, 31'h20, 32'hA5A55A5A);
      push_req(1, 16'd31, 1'b1, 31'h20, 32'h0);
      push_req(2, 16'd32, 1'b1, 31'h30, 32'h0);
      drain(50);

      // Randomized traffic with random back-pressure
      repeat (400) begin
         for (int c = 0; c < NUM_CH; c++)
            if ($urandom_range(2) == 0 && fq[c].size() < 4)
               push_req(c, 16'($urandom), 1'($urandom), rand_addr(), $urandom);
         full_m = ($urandom_range(3) == 0);
         step();
      end
      full_m = 1'b0;
      drain(200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
